// File: rtl/up_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : up_down_counter
// Description : Synchronous, loadable, bidirectional binary counter.
//               On every rising edge of Clock the count is cleared, parallel
//               loaded, incremented or decremented (in that priority order).
//               Arithmetic is unsigned and wraps modulo 2^WIDTH.
// Ports       : Clock         - system clock, rising-edge active
//               Reset         - synchronous active-high clear
//               UpDown        - 1 = count up, 0 = count down
//               LoadCount     - synchronous parallel-load strobe
//               CounterLoad   - value loaded while LoadCount = 1
//               CounterOutput - current count, straight from the register
// Revision    : 1.0 - initial release
// ============================================================================
module up_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             UpDown,
    input  logic             LoadCount,
    input  logic [WIDTH-1:0] CounterLoad,
    output logic [WIDTH-1:0] CounterOutput
);

    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_nextCount;

    // Wrap-around falls out of the WIDTH-bit truncation of the sum/difference.
    always_comb begin
        w_nextCount = r_count;
        if (LoadCount) begin
            w_nextCount = CounterLoad;
        end else if (UpDown) begin
            w_nextCount = r_count + c_ONE;
        end else begin
            w_nextCount = r_count - c_ONE;
        end
    end

    // Reset dominates load and count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count <= c_ZERO;
        end else begin
            r_count <= w_nextCount;
        end
    end

    assign CounterOutput = r_count;

endmodule
`default_nettype wire

// File: tb/tb_up_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_up_down_counter
// Description : Self-checking bench for up_down_counter. Directed sequences
//               followed by random stimulus, compared against a behavioural
//               modulo-2^WIDTH reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_down_counter;

    localparam int c_WIDTH = 4;
    localparam int c_MOD   = 1 << c_WIDTH;

    logic               Clock;
    logic               Reset;
    logic               UpDown;
    logic               LoadCount;
    logic [c_WIDTH-1:0] CounterLoad;
    logic [c_WIDTH-1:0] CounterOutput;

    int checkCount;
    int failCount;
    int modelCount;
    bit modelValid;

    up_down_counter #(
        .WIDTH(c_WIDTH)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .UpDown       (UpDown),
        .LoadCount    (LoadCount),
        .CounterLoad  (CounterLoad),
        .CounterOutput(CounterOutput)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkValue(input string tag,
                              input logic [c_WIDTH-1:0] observed,
                              input logic [c_WIDTH-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock of stimulus. Inputs change after the falling edge; the output
    // must not move until the next rising edge, then must match the model.
    task automatic step(input bit rst, input bit ld,
                        input logic [c_WIDTH-1:0] loadVal, input bit up,
                        input string tag);
        @(negedge Clock);
        Reset       = rst;
        LoadCount   = ld;
        CounterLoad = loadVal;
        UpDown      = up;
        #1;
        if (modelValid)
            checkValue({tag, "_hold"}, CounterOutput, c_WIDTH'(modelCount));
        @(posedge Clock);
        #1;
        if (rst)
            modelCount = 0;
        else if (ld)
            modelCount = int'(loadVal);
        else if (up)
            modelCount = (modelCount + 1) % c_MOD;
        else
            modelCount = (modelCount + c_MOD - 1) % c_MOD;
        if (rst)
            modelValid = 1'b1;
        if (modelValid)
            checkValue(tag, CounterOutput, c_WIDTH'(modelCount));
    endtask

    initial begin
        checkCount  = 0;
        failCount   = 0;
        modelCount  = 0;
        modelValid  = 1'b0;
        Reset       = 1'b0;
        UpDown      = 1'b0;
        LoadCount   = 1'b0;
        CounterLoad = '0;

        // Reset then count up 0..7
        step(1, 0, 4'h0, 0, "reset");
        checkValue("reset_zero", CounterOutput, 4'h0);
        for (int i = 0; i < 7; i++) step(0, 0, 4'h0, 1, "count_up");
        checkValue("up_reach7", CounterOutput, 4'h7);

        // Direction switch at 7: next edge gives 6
        step(0, 0, 4'h0, 0, "dir_switch");
        checkValue("dir_switch_6", CounterOutput, 4'h6);

        // Up wrap from E
        step(0, 1, 4'hE, 1, "load_E");
        for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 1, "up_wrap");
        checkValue("up_wrap_1", CounterOutput, 4'h1);

        // Down wrap from 2
        step(0, 1, 4'h2, 0, "load_2");
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 0, "down_wrap");
        checkValue("down_wrap_E", CounterOutput, 4'hE);

        // Load priority: held load with toggling UpDown, then release down
        for (int i = 0; i < 4; i++) step(0, 1, 4'hA, i[0], "load_hold");
        checkValue("load_hold_A", CounterOutput, 4'hA);
        step(0, 0, 4'h0, 0, "load_release");
        step(0, 0, 4'h0, 0, "load_release");
        checkValue("load_release_8", CounterOutput, 4'h8);

        // Reset beats load and count
        step(1, 1, 4'h5, 1, "rst_over_load");
        checkValue("rst_over_load_0", CounterOutput, 4'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 4'h0, 1, "rst_hold");
        // Release into a load
        step(0, 1, 4'h3, 1, "rst_release_load");
        step(1, 0, 4'h0, 1, "rst_mid_count");
        step(0, 0, 4'h0, 0, "rst_release_down");
        checkValue("rst_release_F", CounterOutput, 4'hF);

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 5) == 0),
                 c_WIDTH'($urandom),
                 $urandom_range(0, 1) == 1,
                 "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire
